// File: rtl/dmem_port_if.sv
// Request/response bundle between the memory stage and the multi-cycle data memory.
// The master drives a request; the slave reports progress and the load result.
interface dmem_port_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] w_data;
  logic [3:0]  byte_en;
  logic [31:0] r_data;
  logic [1:0]  status;

  modport master (output req, we, addr, w_data, byte_en, input r_data, status);
  modport slave  (input req, we, addr, w_data, byte_en, output r_data, status);
endinterface

// File: rtl/dmem_port.sv
// Multi-cycle data memory: one request at a time, fixed latency, byte-lane stores,
// alignment/range checking, and a 2-bit status (00 idle, 01 busy, 10 done, 11 error).
module dmem_port #(
  parameter logic [31:0] BASE_ADDR   = 32'h1001_0000,
  parameter int          DEPTH_WORDS = 1024,
  parameter int          LATENCY     = 3
) (
  input  logic        clk,
  input  logic        rst,
  dmem_port_if.slave  bus
);

  localparam int IDX_W      = $clog2(DEPTH_WORDS);
  localparam int CNT_W      = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int CNT_LOAD_I = (LATENCY > 1) ? LATENCY - 2 : 0;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_LOAD_I[CNT_W-1:0];
  localparam logic [31:0]      SPAN     = 32'(DEPTH_WORDS * 4);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_BUSY = 2'b01,
    S_DONE = 2'b10,
    S_ERR  = 2'b11
  } state_t;

  logic [31:0] mem [DEPTH_WORDS];

  state_t           state_q, state_d;
  logic [1:0]       status_q, status_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             we_q, we_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [3:0]       be_q, be_d;
  logic [31:0]      r_data_q, r_data_d;

  logic [31:0]      offset;
  logic             req_err;
  logic             acc_fire;
  logic             acc_we;
  logic [IDX_W-1:0] acc_idx;
  logic [31:0]      acc_wdata;
  logic [3:0]       acc_be;
  logic [31:0]      old_word;
  logic [31:0]      merged;

  // Out-of-range includes addresses below BASE_ADDR, which wrap to large offsets.
  assign offset  = bus.addr - BASE_ADDR;
  assign req_err = (bus.addr[1:0] != 2'b00) || (offset >= SPAN);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    we_d      = we_q;
    idx_d     = idx_q;
    wdata_d   = wdata_q;
    be_d      = be_q;
    r_data_d  = r_data_q;
    acc_fire  = 1'b0;
    acc_we    = we_q;
    acc_idx   = idx_q;
    acc_wdata = wdata_q;
    acc_be    = be_q;

    case (state_q)
      S_BUSY: begin
        if (cnt_q == '0) begin
          acc_fire = 1'b1;
          state_d  = S_DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        if (bus.req) begin
          we_d    = bus.we;
          idx_d   = offset[IDX_W+1:2];
          wdata_d = bus.w_data;
          be_d    = bus.byte_en;
          if (req_err) begin
            state_d = S_ERR;
          end else if (LATENCY == 1) begin
            // Single-cycle build: the access happens on the accepting edge itself.
            state_d   = S_DONE;
            acc_fire  = 1'b1;
            acc_we    = bus.we;
            acc_idx   = offset[IDX_W+1:2];
            acc_wdata = bus.w_data;
            acc_be    = bus.byte_en;
          end else begin
            state_d = S_BUSY;
            cnt_d   = CNT_LOAD;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
    endcase

    old_word = mem[acc_idx];
    for (int i = 0; i < 4; i++) begin
      merged[8*i +: 8] = (acc_we && acc_be[i]) ? acc_wdata[8*i +: 8] : old_word[8*i +: 8];
    end

    // Stores report the post-write word, loads the stored word.
    if (acc_fire) begin
      r_data_d = merged;
    end

    status_d = state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      status_q <= 2'b00;
      cnt_q    <= '0;
      we_q     <= 1'b0;
      idx_q    <= '0;
      wdata_q  <= '0;
      be_q     <= '0;
      r_data_q <= '0;
    end else begin
      state_q  <= state_d;
      status_q <= status_d;
      cnt_q    <= cnt_d;
      we_q     <= we_d;
      idx_q    <= idx_d;
      wdata_q  <= wdata_d;
      be_q     <= be_d;
      r_data_q <= r_data_d;
    end
  end

  // Array is not reset; a store sampled while rst is high must never commit.
  always_ff @(posedge clk) begin
    if (acc_fire && acc_we && !rst) begin
      mem[acc_idx] <= merged;
    end
  end

  assign bus.r_data = r_data_q;
  assign bus.status = status_q;

endmodule
